// File: rtl/ds_msg_sender.sv
// Round-robin multi-beat NoC data-stream traffic source driving the TX side of a horizontal NAP.
// Optional stall counter is built only when DS_MSG_SENDER_STALL_CNT_EN is defined.
module ds_msg_sender #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_DEST   = 4,
    parameter int BEATS_W    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [31:0]                  interval,
    input  logic [BEATS_W-1:0]           beats,
    input  logic [NUM_DEST*ADDR_WIDTH-1:0] dest_addr,
    input  logic [NUM_DEST-1:0]          dest_mask,
    output logic                         ds_valid,
    input  logic                         ds_ready,
    output logic [DATA_WIDTH-1:0]        ds_data,
    output logic [ADDR_WIDTH-1:0]        ds_addr,
    output logic                         ds_sop,
    output logic                         ds_eop,
    output logic                         busy,
    output logic [31:0]                  msgs_sent,
    output logic [31:0]                  stall_cycles
);
    localparam int IDX_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t               state;
    logic [31:0]          cnt;
    logic [31:0]          seq;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     dest_idx;
    logic [BEATS_W-1:0]   beat_idx;
    logic [BEATS_W-1:0]   beat_last;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     next_ptr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BEATS_W-1:0]   req_last;
    logic                 more;

    // First eligible slot at or after start, searching upward with wrap.
    function automatic logic [IDX_W-1:0] pick_dest(input logic [NUM_DEST-1:0] mask,
                                                   input logic [IDX_W-1:0]    start);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] idx;
        logic             found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_DEST; i++) begin
            idx = IDX_W'((int'(start) + i) % NUM_DEST);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Payload layout: seq in the low word so a byte-wide LED receiver still sees seq[7:0].
    function automatic logic [DATA_WIDTH-1:0] make_data(input logic [31:0] s,
                                                        input logic [7:0]  b,
                                                        input logic [7:0]  d);
        logic [DATA_WIDTH-1:0] v;
        v        = '0;
        v[31:0]  = s;
        v[39:32] = b;
        v[47:40] = d;
        return v;
    endfunction

    // Destination choice, its address and the latched last-beat index.
    always_comb begin
        sel      = pick_dest(dest_mask, ptr);
        next_ptr = (int'(sel) == NUM_DEST - 1) ? IDX_W'(0) : sel + IDX_W'(1);
        sel_addr = '0;
        for (int k = 0; k < NUM_DEST; k++) begin
            sel_addr = (sel == IDX_W'(k)) ? dest_addr[k*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr;
        end
        req_last = (beats == '0) ? '0 : beats - BEATS_W'(1);
        more     = enable && (dest_mask != '0);
    end

    // Message sequencing FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 32'd0;
            seq       <= 32'd0;
            ptr       <= '0;
            dest_idx  <= '0;
            beat_idx  <= '0;
            beat_last <= '0;
            busy      <= 1'b0;
            ds_valid  <= 1'b0;
            ds_sop    <= 1'b0;
            ds_eop    <= 1'b0;
            ds_data   <= '0;
            ds_addr   <= '0;
            msgs_sent <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (more) begin
                        state <= WAIT;
                        cnt   <= interval;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (dest_mask == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == 32'd0) begin
                        state     <= SEND;
                        ds_valid  <= 1'b1;
                        ds_sop    <= 1'b1;
                        ds_eop    <= (req_last == '0);
                        ds_addr   <= sel_addr;
                        ds_data   <= make_data(seq, 8'd0, 8'(sel));
                        dest_idx  <= sel;
                        beat_idx  <= '0;
                        beat_last <= req_last;
                        ptr       <= next_ptr;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                SEND: begin
                    if (ds_ready) begin
                        if (beat_idx == beat_last) begin
                            ds_valid  <= 1'b0;
                            ds_sop    <= 1'b0;
                            ds_eop    <= 1'b0;
                            seq       <= seq + 32'd1;
                            msgs_sent <= msgs_sent + 32'd1;
                            if (more) begin
                                state <= WAIT;
                                cnt   <= interval;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            beat_idx <= beat_idx + BEATS_W'(1);
                            ds_data  <= make_data(seq, 8'(beat_idx + BEATS_W'(1)), 8'(dest_idx));
                            ds_sop   <= 1'b0;
                            ds_eop   <= ((beat_idx + BEATS_W'(1)) == beat_last);
                        end
                    end else begin
                        state <= SEND;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ds_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DS_MSG_SENDER_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of presented-but-refused beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (ds_valid && !ds_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ds_msg_sender.sv
// Directed self-checking bench for ds_msg_sender: stimulus driven and outputs sampled on the falling edge.
module tb_ds_msg_sender;
    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [31:0]  interval;
    logic [3:0]   beats;
    logic [15:0]  dest_addr;
    logic [3:0]   dest_mask;
    logic         ds_valid;
    logic         ds_ready;
    logic [255:0] ds_data;
    logic [3:0]   ds_addr;
    logic         ds_sop;
    logic         ds_eop;
    logic         busy;
    logic [31:0]  msgs_sent;
    logic [31:0]  stall_cycles;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    ds_msg_sender dut (
        .clk(clk), .reset(reset), .enable(enable), .interval(interval), .beats(beats),
        .dest_addr(dest_addr), .dest_mask(dest_mask), .ds_valid(ds_valid), .ds_ready(ds_ready),
        .ds_data(ds_data), .ds_addr(ds_addr), .ds_sop(ds_sop), .ds_eop(ds_eop), .busy(busy),
        .msgs_sent(msgs_sent), .stall_cycles(stall_cycles)
    );

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ds_valid !== 1'b1 && n < 40);
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] addr, input logic [7:0] d,
                            input logic [7:0] b, input logic [31:0] s, input logic sop, input logic eop);
        chk({tag, ".valid"}, 64'(ds_valid), 64'd1);
        chk({tag, ".sop"}, 64'(ds_sop), 64'(sop));
        chk({tag, ".eop"}, 64'(ds_eop), 64'(eop));
        chk({tag, ".addr"}, 64'(ds_addr), 64'(addr));
        chk({tag, ".data"}, ds_data[63:0], {16'h0000, d, b, s});
        chk({tag, ".hi"}, 64'(|ds_data[255:48]), 64'd0);
    endtask

    initial begin
        int n;
        int sop_cyc;
        logic [7:0] rr_dest [4];
        logic [3:0] rr_addr [4];
        rr_dest[0] = 8'd1; rr_dest[1] = 8'd3; rr_dest[2] = 8'd1; rr_dest[3] = 8'd3;
        rr_addr[0] = 4'd5; rr_addr[1] = 4'd9; rr_addr[2] = 4'd5; rr_addr[3] = 4'd9;
        sop_cyc = 0;

        reset = 1'b1; enable = 1'b0; interval = 32'd0; beats = 4'd1;
        dest_addr = {4'd9, 4'd7, 4'd5, 4'd2}; dest_mask = 4'b0001; ds_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst.valid", 64'(ds_valid), 64'd0);
        chk("rst.sop", 64'(ds_sop), 64'd0);
        chk("rst.eop", 64'(ds_eop), 64'd0);
        chk("rst.data", ds_data[63:0], 64'd0);
        chk("rst.addr", 64'(ds_addr), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.msgs", 64'(msgs_sent), 64'd0);
        chk("rst.stall", 64'(stall_cycles), 64'd0);

        // Basic single-beat send with a one-cycle enable pulse.
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("basic.busy_wait", 64'(busy), 64'd1);
        chk("basic.valid_wait", 64'(ds_valid), 64'd0);
        step();
        chk_beat("basic", 4'd2, 8'd0, 8'd0, 32'd0, 1'b1, 1'b1);
        step();
        chk("basic.valid_end", 64'(ds_valid), 64'd0);
        chk("basic.busy_end", 64'(busy), 64'd0);
        chk("basic.msgs", 64'(msgs_sent), 64'd1);

        // Round-robin over slots 1 and 3, three beats, gap of five.
        dest_mask = 4'b1010; beats = 4'd3; interval = 32'd5; enable = 1'b1;
        for (int m = 0; m < 4; m++) begin
            wait_valid(n);
            chk("rr.latency", 64'(n), 64'd7);
            if (m > 0) chk("rr.sop_gap", 64'(cyc - sop_cyc), 64'd9);
            sop_cyc = cyc;
            for (int b = 0; b < 3; b++) begin
                chk_beat("rr", rr_addr[m], rr_dest[m], 8'(b), 32'(m + 1), (b == 0), (b == 2));
                if (b < 2) step();
            end
        end
        enable = 1'b0;
        step();
        chk("rr.busy_end", 64'(busy), 64'd0);
        chk("rr.msgs", 64'(msgs_sent), 64'd5);

        // Backpressure on beat 1 of 4, with enable dropped mid-message.
        dest_mask = 4'b0001; beats = 4'd4; interval = 32'd0; enable = 1'b1;
        wait_valid(n);
        chk("bp.latency", 64'(n), 64'd2);
        chk_beat("bp.b0", 4'd2, 8'd0, 8'd0, 32'd5, 1'b1, 1'b0);
        step();
        chk_beat("bp.b1", 4'd2, 8'd0, 8'd1, 32'd5, 1'b0, 1'b0);
        ds_ready = 1'b0; enable = 1'b0;
        for (int s = 0; s < 7; s++) begin
            step();
            chk_beat("bp.hold", 4'd2, 8'd0, 8'd1, 32'd5, 1'b0, 1'b0);
        end
`ifdef DS_MSG_SENDER_STALL_CNT_EN
        chk("bp.stall", 64'(stall_cycles), 64'd7);
`else
        chk("bp.stall", 64'(stall_cycles), 64'd0);
`endif
        ds_ready = 1'b1;
        step();
        chk_beat("bp.b2", 4'd2, 8'd0, 8'd2, 32'd5, 1'b0, 1'b0);
        step();
        chk_beat("bp.b3", 4'd2, 8'd0, 8'd3, 32'd5, 1'b0, 1'b1);
        step();
        chk("en_drop.busy", 64'(busy), 64'd0);
        chk("en_drop.msgs", 64'(msgs_sent), 64'd6);
        repeat (4) step();
        chk("en_drop.no_valid", 64'(ds_valid), 64'd0);

        // beats=0 behaves as a single-beat message.
        beats = 4'd0; interval = 32'd2; enable = 1'b1;
        wait_valid(n);
        chk("b0.latency", 64'(n), 64'd4);
        chk_beat("b0", 4'd2, 8'd0, 8'd0, 32'd6, 1'b1, 1'b1);
        enable = 1'b0;
        step();
        chk("b0.busy_end", 64'(busy), 64'd0);
        chk("b0.msgs", 64'(msgs_sent), 64'd7);

        // Mask cleared while waiting returns to idle without sending.
        beats = 4'd1; interval = 32'd10; enable = 1'b1;
        step();
        chk("mask.busy_wait", 64'(busy), 64'd1);
        repeat (2) step();
        dest_mask = 4'b0000; enable = 1'b0;
        step();
        chk("mask.busy_end", 64'(busy), 64'd0);
        repeat (12) step();
        chk("mask.no_valid", 64'(ds_valid), 64'd0);
        chk("mask.msgs", 64'(msgs_sent), 64'd7);

        // Sequence number wraps from all-ones to zero.
        force dut.seq = 32'hFFFF_FFFF;
        step();
        release dut.seq;
        dest_mask = 4'b0001; interval = 32'd0; enable = 1'b1;
        wait_valid(n);
        chk_beat("wrap.max", 4'd2, 8'd0, 8'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_valid(n);
        chk("wrap.latency", 64'(n), 64'd2);
        chk_beat("wrap.zero", 4'd2, 8'd0, 8'd0, 32'd0, 1'b1, 1'b1);
        enable = 1'b0;
        step();
        chk("wrap.msgs", 64'(msgs_sent), 64'd9);

        // Reset asserted while beat 2 of 4 is presented.
        beats = 4'd4; enable = 1'b1;
        wait_valid(n);
        step();
        step();
        chk_beat("rstmid.b2", 4'd2, 8'd0, 8'd2, 32'd1, 1'b0, 1'b0);
        reset = 1'b1; enable = 1'b0;
        step();
        chk("rstmid.valid", 64'(ds_valid), 64'd0);
        chk("rstmid.eop", 64'(ds_eop), 64'd0);
        chk("rstmid.busy", 64'(busy), 64'd0);
        chk("rstmid.msgs", 64'(msgs_sent), 64'd0);
        chk("rstmid.seq", 64'(dut.seq), 64'd0);
        chk("rstmid.ptr", 64'(dut.ptr), 64'd0);
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/ds_msg_sender.md
# ds_msg_sender

Parametrised NoC data-stream traffic source that sends multi-beat messages round-robin to up to NUM_DEST horizontal-NAP destinations. It has a programmable inter-message gap and a global sequence number. It drives the TX side of a horizontal NAP data-stream interface and supersedes the fixed single-destination, single-byte LED sender. Status outputs are intended for direct connection to a Snapshot monitor bus.

## Interface
- DATA_WIDTH, 256: ds_data width; must be ≥ 48.
- ADDR_WIDTH, 4: NoC destination (column/row) address width.
- NUM_DEST, 4: number of destination slots, 1..16.
- BEATS_W, 4: width of the beats-per-message field.
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; high allows new messages to start.
- interval  in  32  idle cycles inserted before each message.
- beats  in  BEATS_W  beats per message; 0 is treated as 1.
- dest_addr  in  NUM_DEST*ADDR_WIDTH  slot k address at [k*ADDR_WIDTH +: ADDR_WIDTH].
- dest_mask  in  NUM_DEST  slot k is eligible when bit k = 1.
- ds_valid  out  1  beat valid.
- ds_ready  in  1  NAP accepts the beat.
- ds_data  out  DATA_WIDTH  beat payload.
- ds_addr  out  ADDR_WIDTH  destination of the current message.
- ds_sop  out  1  first beat of a message.
- ds_eop  out  1  last beat of a message.
- busy  out  1  state ≠ IDLE.
- msgs_sent  out  32  count of completed messages (eop accepted).
- stall_cycles  out  32  see Configuration.

## Operation
- States: IDLE, WAIT, SEND.
- IDLE → WAIT when enable=1 and dest_mask≠0. On entry, latch cnt=interval.
- WAIT: if cnt==0, go to SEND and select the destination; otherwise decrement cnt.
- SEND: ds_valid=1. A beat is accepted when ds_valid && ds_ready. On accepting the last beat:
  - go to WAIT (cnt=interval) if enable=1 and dest_mask≠0;
  - otherwise go to IDLE.
- Destination selection at WAIT→SEND: first set bit of dest_mask at or after ptr, searching upward with wrap. ptr is then set to selected+1 mod NUM_DEST.
- If dest_mask becomes 0 while in WAIT, return to IDLE without sending.
- Latched at SEND entry: ds_addr, beat count (max(beats,1)), dest index. Input changes during SEND do not affect the current message.
- Payload per beat:
  - data[31:0] = seq;
  - data[39:32] = beat index (0-based);
  - data[47:40] = dest index;
  - all upper bits 0.
- data[7:0] carries the low byte of seq, so an existing LED receiver still works.
- seq: starts at 0, increments by 1 per completed message, wraps 2^32−1 → 0.
- sop=1 on beat 0 only. eop=1 on the final beat only. Both are 1 for single-beat messages.
- While ds_valid && !ds_ready, data, addr, sop and eop hold stable.
- Deasserting enable mid-message does not abort it: the message completes, then the block goes to IDLE.
- msgs_sent increments on eop acceptance and wraps.

## Timing
- Reset values: state IDLE, ptr 0, seq 0, cnt 0, busy 0, ds_valid 0, ds_sop 0, ds_eop 0, ds_data 0, ds_addr 0, msgs_sent 0, stall_cycles 0.
- Reset asserted mid-message drops ds_valid at the next edge. No eop is emitted.
- Start latency: enable first sampled high at edge E0 (in IDLE). ds_valid is registered high at edge E0+interval+1.
- Inter-message gap: last beat accepted at edge E. The next sop valid rises at E+interval+1 (one-cycle minimum gap when interval=0).
- Beat throughput: one beat per cycle with ds_ready held high. Beat n+1 is presented the edge after beat n is accepted.
- All outputs are registered. There is no combinational path from ds_ready to ds_valid.

## Configuration
- DS_MSG_SENDER_STALL_CNT_EN defined: stall_cycles counts cycles with ds_valid && !ds_ready. It saturates at 2^32−1 and is cleared only by reset.
- Macro undefined: stall_cycles is tied to 0 and no counter logic is built.

## Test plan
- Basic send: NUM_DEST=4, mask=4'b0001, addr0=2, interval=0, beats=1, ready=1, enable pulse of 1 cycle → one beat with sop=eop=1, addr=2, data[31:0]=0, then IDLE. msgs_sent=1.
- Round-robin: mask=4'b1010, beats=3, interval=5, ready=1 → messages go to dest 1,3,1,3. Each has sop on beat 0, eop on beat 2, data[39:32]=0,1,2. Consecutive sop valids are 3+6=9 cycles apart.
- Backpressure: ready low for 7 cycles mid-message → outputs frozen across the stall. With the macro defined, stall_cycles=7; without it, 0.
- Enable drop: deassert enable after beat 1 of 4 → beats 2–3 are still sent, eop is emitted, then busy=0 and there is no further valid.
- Boundaries: beats=0 → single-beat messages. mask cleared during WAIT → IDLE with no send. seq preloaded to 32'hFFFF_FFFF (forced) → next message carries 0.
- Reset mid-message: assert reset during beat 2 of 4 → ds_valid=0 at the next edge, and seq, msgs_sent and ptr all read 0.
